// File: rtl/signed_sat_accumulator_if.sv
// Sample/result bundle for the multi-channel signed saturating accumulator.
// Handshake: a sample transfers on every clock where in_valid is high (no ready, no backpressure);
// a result is valid for exactly the cycle out_valid is high, and the other out_* signals hold between results.
interface signed_sat_accumulator_if #(
    parameter int W     = 4,
    parameter int ACC_W = 4,
    parameter int N_CH  = 2,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [W-1:0]      in_data;
    logic              in_clear;
    logic              sat_en;
    logic              flag_clr;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [ACC_W-1:0]  out_data;
    logic              out_sat;
    logic [N_CH-1:0]   sat_flags;

    modport master (
        output in_valid, in_ch, in_data, in_clear, sat_en, flag_clr,
        input  out_valid, out_ch, out_data, out_sat, sat_flags
    );

    modport slave (
        input  in_valid, in_ch, in_data, in_clear, sat_en, flag_clr,
        output out_valid, out_ch, out_data, out_sat, sat_flags
    );
endinterface

// File: rtl/signed_sat_accumulator.sv
// Per-channel signed accumulator: one read-modify-write per cycle, saturating or wrapping,
// registered result with per-sample clamp indication and sticky per-channel clamp flags.
module signed_sat_accumulator #(
    parameter int W     = 4,
    parameter int ACC_W = 4,
    parameter int N_CH  = 2,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input logic                     clk,
    input logic                     rst,
    signed_sat_accumulator_if.slave bus
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    generate
        if (ACC_W < W) begin : g_bad_acc_w
            $error("ACC_W (%0d) must be >= W (%0d)", ACC_W, W);
        end
        if (N_CH < 1) begin : g_bad_n_ch
            $error("N_CH (%0d) must be >= 1", N_CH);
        end
    endgenerate

    logic [ACC_W-1:0]  acc_q [N_CH];
    logic [ACC_W-1:0]  acc_d [N_CH];
    logic [N_CH-1:0]   flags_q, flags_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;
    logic              out_sat_q, out_sat_d;

    logic              accept;
    logic signed [W-1:0] din_s;
    logic [ACC_W-1:0]  x;
    logic [ACC_W-1:0]  acc_cur;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  result;
    logic              ovf;
    logic              sat;

    // Out-of-range channel codes are simply not accepted; nothing downstream sees them.
    assign accept = bus.in_valid && (32'(bus.in_ch) < N_CH);
    assign din_s  = bus.in_data;
    assign x      = ACC_W'(din_s);

    always_comb begin
        acc_cur = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (32'(bus.in_ch) == c) begin
                acc_cur = acc_q[c];
            end
        end
    end

    assign sum = acc_cur + x;
    assign ovf = (acc_cur[ACC_W-1] == x[ACC_W-1]) && (sum[ACC_W-1] != acc_cur[ACC_W-1]);

    always_comb begin
        result = sum;
        sat    = 1'b0;
        if (bus.in_clear) begin
            result = x;
        end else if (bus.sat_en && ovf) begin
            result = x[ACC_W-1] ? ACC_MIN : ACC_MAX;
            sat    = 1'b1;
        end
    end

    // A flag set in the same cycle as flag_clr wins for that channel.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            acc_d[c]   = acc_q[c];
            flags_d[c] = flags_q[c] & ~bus.flag_clr;
            if (accept && (32'(bus.in_ch) == c)) begin
                acc_d[c]   = result;
                flags_d[c] = flags_d[c] | sat;
            end
        end
    end

    always_comb begin
        out_valid_d = accept;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (accept) begin
            out_ch_d   = bus.in_ch;
            out_data_d = result;
            out_sat_d  = sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c] <= '0;
            end
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                acc_q[c] <= acc_d[c];
            end
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.sat_flags = flags_q;
endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench for signed_sat_accumulator: base build (4/4/2), wide accumulator (4/8/2)
// and three-channel build (4/4/3) for out-of-range channel codes.
module tb_signed_sat_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    signed_sat_accumulator_if #(.W(4), .ACC_W(4), .N_CH(2)) if_a ();
    signed_sat_accumulator_if #(.W(4), .ACC_W(8), .N_CH(2)) if_b ();
    signed_sat_accumulator_if #(.W(4), .ACC_W(4), .N_CH(3)) if_c ();

    signed_sat_accumulator #(.W(4), .ACC_W(4), .N_CH(2)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    signed_sat_accumulator #(.W(4), .ACC_W(8), .N_CH(2)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    signed_sat_accumulator #(.W(4), .ACC_W(4), .N_CH(3)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        {if_a.in_valid, if_a.in_ch, if_a.in_data, if_a.in_clear, if_a.sat_en, if_a.flag_clr} = '0;
        {if_b.in_valid, if_b.in_ch, if_b.in_data, if_b.in_clear, if_b.sat_en, if_b.flag_clr} = '0;
        {if_c.in_valid, if_c.in_ch, if_c.in_data, if_c.in_clear, if_c.sat_en, if_c.flag_clr} = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_all();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_a(input logic v, input logic ch, input logic [3:0] d,
                           input logic clr, input logic se, input logic fc);
        @(negedge clk);
        if_a.in_valid = v;
        if_a.in_ch    = ch;
        if_a.in_data  = d;
        if_a.in_clear = clr;
        if_a.sat_en   = se;
        if_a.flag_clr = fc;
        @(posedge clk);
        #1;
        if_a.in_valid = 1'b0;
        if_a.in_clear = 1'b0;
        if_a.flag_clr = 1'b0;
    endtask

    task automatic exp_a(input string tag, input logic v, input logic ch, input logic [3:0] d,
                         input logic sat, input logic [1:0] flags);
        chk({tag, ".valid"}, 32'(if_a.out_valid), 32'(v));
        chk({tag, ".ch"},    32'(if_a.out_ch),    32'(ch));
        chk({tag, ".data"},  32'(if_a.out_data),  32'(d));
        chk({tag, ".sat"},   32'(if_a.out_sat),   32'(sat));
        chk({tag, ".flags"}, 32'(if_a.sat_flags), 32'(flags));
    endtask

    task automatic drive_b(input logic ch, input logic [3:0] d);
        @(negedge clk);
        if_b.in_valid = 1'b1;
        if_b.in_ch    = ch;
        if_b.in_data  = d;
        if_b.sat_en   = 1'b1;
        @(posedge clk);
        #1;
        if_b.in_valid = 1'b0;
    endtask

    task automatic drive_c(input logic [1:0] ch, input logic [3:0] d);
        @(negedge clk);
        if_c.in_valid = 1'b1;
        if_c.in_ch    = ch;
        if_c.in_data  = d;
        if_c.sat_en   = 1'b1;
        @(posedge clk);
        #1;
        if_c.in_valid = 1'b0;
    endtask

    task automatic exp_c(input string tag, input logic v, input logic [1:0] ch, input logic [3:0] d);
        chk({tag, ".valid"}, 32'(if_c.out_valid), 32'(v));
        chk({tag, ".ch"},    32'(if_c.out_ch),    32'(ch));
        chk({tag, ".data"},  32'(if_c.out_data),  32'(d));
    endtask

    initial begin
        int         e;
        logic [7:0] e8;

        idle_all();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_a("reset_a", 1'b0, 1'b0, 4'h0, 1'b0, 2'b00);
        chk("reset_b.valid", 32'(if_b.out_valid), 32'd0);
        chk("reset_b.data",  32'(if_b.out_data),  32'd0);
        chk("reset_c.flags", 32'(if_c.sat_flags), 32'd0);
        rst = 1'b0;

        // Basic add and positive clamp on ch0
        drive_a(1'b1, 1'b0, 4'h4, 1'b0, 1'b1, 1'b0); exp_a("add4",    1'b1, 1'b0, 4'h4, 1'b0, 2'b00);
        drive_a(1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 1'b0); exp_a("clamp7",  1'b1, 1'b0, 4'h7, 1'b1, 2'b01);
        drive_a(1'b1, 1'b0, 4'hF, 1'b0, 1'b1, 1'b0); exp_a("sub1",    1'b1, 1'b0, 4'h6, 1'b0, 2'b01);
        drive_a(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0); exp_a("idle1",   1'b0, 1'b0, 4'h6, 1'b0, 2'b01);

        // Negative clamp and mixed-sign adds on ch1
        do_reset();
        drive_a(1'b1, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0); exp_a("neg4",    1'b1, 1'b1, 4'hC, 1'b0, 2'b00);
        drive_a(1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0); exp_a("clampm8", 1'b1, 1'b1, 4'h8, 1'b1, 2'b10);
        drive_a(1'b1, 1'b1, 4'h3, 1'b0, 1'b1, 1'b0); exp_a("mix3",    1'b1, 1'b1, 4'hB, 1'b0, 2'b10);
        drive_a(1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0); exp_a("mix5",    1'b1, 1'b1, 4'h0, 1'b0, 2'b10);

        // Wrap mode: overflow wraps silently
        do_reset();
        drive_a(1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0); exp_a("wrap4",   1'b1, 1'b0, 4'h4, 1'b0, 2'b00);
        drive_a(1'b1, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0); exp_a("wrap7",   1'b1, 1'b0, 4'hB, 1'b0, 2'b00);

        // Interleave, clear and sticky flags
        do_reset();
        drive_a(1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0); exp_a("il_c0_3", 1'b1, 1'b0, 4'h3, 1'b0, 2'b00);
        drive_a(1'b1, 1'b1, 4'hE, 1'b0, 1'b1, 1'b0); exp_a("il_c1_m2",1'b1, 1'b1, 4'hE, 1'b0, 2'b00);
        drive_a(1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0); exp_a("il_c0_5", 1'b1, 1'b0, 4'h7, 1'b1, 2'b01);
        drive_a(1'b1, 1'b1, 4'h6, 1'b1, 1'b1, 1'b0); exp_a("il_clr6", 1'b1, 1'b1, 4'h6, 1'b0, 2'b01);
        drive_a(1'b1, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1); exp_a("set_win", 1'b1, 1'b0, 4'h7, 1'b1, 2'b01);
        drive_a(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1); exp_a("fclr",    1'b0, 1'b0, 4'h7, 1'b1, 2'b00);
        drive_a(1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1'b0); exp_a("il_c1_1", 1'b1, 1'b1, 4'h7, 1'b0, 2'b00);

        // Wide accumulator: ramp to +127 on ch0, to -128 on ch1
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            drive_b(1'b0, 4'h7);
            e  = (7 * k > 127) ? 127 : 7 * k;
            e8 = 8'(e);
            chk("wide_pos.data", 32'(if_b.out_data), 32'(e8));
            chk("wide_pos.sat",  32'(if_b.out_sat),  32'(k >= 19));
        end
        for (int k = 1; k <= 20; k++) begin
            drive_b(1'b1, 4'h8);
            e  = (-8 * k < -128) ? -128 : -8 * k;
            e8 = 8'(e);
            chk("wide_neg.data", 32'(if_b.out_data), 32'(e8));
            chk("wide_neg.sat",  32'(if_b.out_sat),  32'(k >= 17));
        end
        chk("wide.flags", 32'(if_b.sat_flags), 32'b11);

        // Reset mid-stream with a sample presented during reset
        do_reset();
        drive_a(1'b1, 1'b0, 4'h5, 1'b0, 1'b1, 1'b0); exp_a("pre_rst", 1'b1, 1'b0, 4'h5, 1'b0, 2'b00);
        drive_a(1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
        drive_a(1'b1, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0); exp_a("c1_sat",  1'b1, 1'b1, 4'h8, 1'b1, 2'b10);
        @(negedge clk);
        rst           = 1'b1;
        if_a.in_valid = 1'b1;
        if_a.in_ch    = 1'b0;
        if_a.in_data  = 4'h3;
        if_a.sat_en   = 1'b1;
        @(posedge clk);
        #1;
        if_a.in_valid = 1'b0;
        exp_a("mid_rst", 1'b0, 1'b0, 4'h0, 1'b0, 2'b00);
        rst = 1'b0;
        drive_a(1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 1'b0); exp_a("post_rst",1'b1, 1'b0, 4'h2, 1'b0, 2'b00);

        // Three-channel build: channel code 3 is ignored
        drive_c(2'd2, 4'h5); exp_c("c_ch2",   1'b1, 2'd2, 4'h5);
        drive_c(2'd3, 4'h4); exp_c("c_bad",   1'b0, 2'd2, 4'h5);
        drive_c(2'd2, 4'h1); exp_c("c_ch2b",  1'b1, 2'd2, 4'h6);
        drive_c(2'd0, 4'h1); exp_c("c_ch0",   1'b1, 2'd0, 4'h1);
        chk("c.flags", 32'(if_c.sat_flags), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
